mux_scan: RTL and testbench
===========================

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 4, meaning bits per channel (WIDTH >= 1).
REQ-002 The block SHALL expose parameter CHANNELS, default 16, meaning input channel count (2..256).
REQ-003 The block SHALL expose parameter DWELL, default 1, meaning cycles each channel is held in scan mode (1..65535).
REQ-004 The block SHALL derive localparam SEL_W = clog2(CHANNELS); it is not user-settable.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port X, input, CHANNELS*WIDTH bits: packed inputs, channel k at X[k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port sel, input, SEL_W bits: manual channel select.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = manual, 1 = auto-scan.
REQ-010 The block SHALL have port en, input, 1 bit: operation enable.
REQ-011 The block SHALL have port Y, output, WIDTH bits: registered selected data.
REQ-012 The block SHALL have port ch, output, SEL_W bits: channel index currently presented on Y.
REQ-013 The block SHALL have port valid, output, 1 bit: Y/ch hold a fresh sample this cycle.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on scan wrap.
REQ-015 The block SHALL have port err, output, 1 bit: registered flag for an out-of-range manual sel.

Function
REQ-016 The block SHALL implement FSM states IDLE, MANUAL and SCAN, with all outputs registered.
REQ-017 From any state, en=0 SHALL go to IDLE; en=1 with mode=0 SHALL go to MANUAL; en=1 with mode=1 SHALL go to SCAN.
REQ-018 IDLE: Y and ch SHALL hold their last values, valid=0, wrap=0, and the scan counter and dwell counter SHALL hold.
REQ-019 MANUAL: on every enabled edge Y<=X[sel] and ch<=sel, with valid=1 one cycle after the edge where sel is sampled (latency 1).
REQ-020 MANUAL: if sel >= CHANNELS, the block SHALL set Y<=0, ch<=sel, err<=1 and valid<=1; otherwise err<=0.
REQ-021 SCAN: on every enabled edge Y<=X[cnt] and ch<=cnt, with valid=1; X is resampled each cycle, including during a dwell.
REQ-022 SCAN: the dwell counter SHALL count 0..DWELL-1; on the cycle it reaches DWELL-1 it SHALL reload to 0 and cnt SHALL advance.
REQ-023 SCAN: cnt=CHANNELS-1 advancing SHALL wrap to 0, and wrap SHALL be 1 on the edge where Y first shows channel 0 after the wrap; otherwise wrap=0.
REQ-024 Entry into SCAN from MANUAL or from reset SHALL clear cnt and the dwell counter, so the first scanned sample is channel 0.
REQ-025 Entry into SCAN from IDLE, when the prior active state was SCAN, SHALL resume cnt and the dwell counter unchanged (pause/resume).
REQ-026 In SCAN, err SHALL be 0 and sel SHALL be ignored.
REQ-027 A mode change while en=1 SHALL take effect on the next edge with no idle cycle; the sample on that edge follows the new mode.
REQ-028 DWELL=1 SHALL advance one channel per cycle with no stall.
REQ-029 When CHANNELS is not a power of two, cnt SHALL never exceed CHANNELS-1.

Reset
REQ-030 rst_n=0 SHALL asynchronously force Y=0, ch=0, valid=0, wrap=0, err=0, cnt=0, the dwell counter to 0, state=IDLE and the prior-active flag to MANUAL.
REQ-031 Reset deassertion SHALL be synchronous in effect: the first sample is taken on the first rising clk edge with rst_n=1 and en=1.
REQ-032 Reset asserted mid-scan SHALL abandon the scan; after release, SCAN restarts at channel 0.

Verification (WIDTH=4, CHANNELS=4, DWELL=1, X=16'h1234: ch0=4, ch1=3, ch2=2, ch3=1)
REQ-033 Manual sweep: en=1, mode=0, sel=0,1,2,3 on consecutive edges -> Y=4,3,2,1 with valid=1, each one cycle after its sel.
REQ-034 Scan wrap: en=1, mode=1 for 6 cycles -> Y=4,3,2,1,4,3, ch=0,1,2,3,0,1, and wrap=1 only on the 5th sample.
REQ-035 Pause/resume: scan to ch=2, drop en for 3 cycles, then raise en -> valid=0 with Y=2 held during the pause; on resume Y=1 (ch=3), then wrap with Y=4.
REQ-036 Dwell: rebuild with DWELL=3, run a scan -> each channel is presented 3 consecutive cycles, and wrap occurs at sample 13.
REQ-037 Mode switch and err: run a scan to ch=2, then mode=0 with sel=1 -> next Y=3, ch=1; then mode=1 -> next Y=4, ch=0. With CHANNELS=3 and sel=3 -> Y=0, err=1.
REQ-038 Reset mid-scan: pulse rst_n low between edges at ch=3 -> all outputs read 0 immediately (async); after release the first sample is Y=4, ch=0.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: registered channel multiplexer with manual select and paused/resumable auto-scan
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 16,
  parameter int DWELL    = 1,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] X,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap,
  output logic                      err
);
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;
  state_t                r_state, w_state_nx;
  logic                  r_prior_scan;
  logic [SEL_W-1:0]      r_cnt, w_cnt, w_cnt_nx;
  logic [15:0]           r_dw, w_dw, w_dw_nx;
  logic [WIDTH-1:0]      w_ch [2**SEL_W];
  logic [WIDTH-1:0]      w_y;
  logic [SEL_W-1:0]      w_ch_o;
  logic                  w_valid, w_wrap, w_err;
  logic                  w_fresh, w_last_dw, w_last_ch, w_in_range;

  // Channel table padded to a power of two; padding slots read as zero so an
  // out-of-range manual select naturally yields Y=0.
  genvar k;
  generate
    for (k = 0; k < 2**SEL_W; k++) begin : g_ch
      if (k < CHANNELS) begin : g_in
        assign w_ch[k] = X[k*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_ch[k] = '0;
      end
    end
  endgenerate

  // State register plus the record of which active mode ran last (for resume)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_prior_scan <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_prior_scan <= en ? mode : r_prior_scan;
    end
  end

  // Next state and next registered outputs; a scan restarts at channel 0 unless resuming a paused scan
  always_comb begin
    w_state_nx = !en ? IDLE : (mode ? SCAN : MANUAL);
    w_fresh    = (r_state == MANUAL) || (r_state == IDLE && !r_prior_scan);
    w_cnt      = w_fresh ? '0 : r_cnt;
    w_dw       = w_fresh ? '0 : r_dw;
    w_last_dw  = 32'(w_dw) == DWELL - 1;
    w_last_ch  = 32'(w_cnt) == CHANNELS - 1;
    w_in_range = 32'(sel) < CHANNELS;
    w_y        = Y;
    w_ch_o     = ch;
    w_valid    = 1'b0;
    w_wrap     = 1'b0;
    w_err      = err;
    w_cnt_nx   = r_cnt;
    w_dw_nx    = r_dw;
    if (w_state_nx == MANUAL) begin
      w_y     = w_ch[sel];
      w_ch_o  = sel;
      w_valid = 1'b1;
      w_err   = !w_in_range;
    end else if (w_state_nx == SCAN) begin
      w_y      = w_ch[w_cnt];
      w_ch_o   = w_cnt;
      w_valid  = 1'b1;
      w_err    = 1'b0;
      w_wrap   = !w_fresh && w_cnt == '0 && w_dw == '0;
      w_dw_nx  = w_last_dw ? '0 : w_dw + 16'd1;
      w_cnt_nx = !w_last_dw ? w_cnt : (w_last_ch ? '0 : w_cnt + SEL_W'(1));
    end
  end

  // Output and scan-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      err   <= 1'b0;
      r_cnt <= '0;
      r_dw  <= '0;
    end else begin
      Y     <= w_y;
      ch    <= w_ch_o;
      valid <= w_valid;
      wrap  <= w_wrap;
      err   <= w_err;
      r_cnt <= w_cnt_nx;
      r_dw  <= w_dw_nx;
    end
  end
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed checks of manual select, scan wrap, pause/resume, dwell, mode switch and reset
module tb_mux_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] x4 = 16'h1234;
  logic [11:0] x3 = 12'h234;
  logic [3:0]  a_y, b_y, c_y;
  logic [1:0]  a_ch, b_ch, c_ch;
  logic        a_valid, b_valid, c_valid;
  logic        a_wrap, b_wrap, c_wrap;
  logic        a_err, b_err, c_err;
  int          n_chk = 0;
  int          n_err = 0;

  mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .X(x4), .sel(sel), .mode(mode), .en(en),
    .Y(a_y), .ch(a_ch), .valid(a_valid), .wrap(a_wrap), .err(a_err));
  mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .X(x4), .sel(sel), .mode(mode), .en(en),
    .Y(b_y), .ch(b_ch), .valid(b_valid), .wrap(b_wrap), .err(b_err));
  mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .X(x3), .sel(sel), .mode(mode), .en(en),
    .Y(c_y), .ch(c_ch), .valid(c_valid), .wrap(c_wrap), .err(c_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int y, input int c, input int v, input int w, input int e);
    chk({tag, " Y"}, a_y, y);
    chk({tag, " ch"}, a_ch, c);
    chk({tag, " valid"}, a_valid, v);
    chk({tag, " wrap"}, a_wrap, w);
    chk({tag, " err"}, a_err, e);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_a("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_a("idle_after_reset", 0, 0, 0, 0, 0);
    en = 1'b1;
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      chk_a($sformatf("manual sel%0d", i), 4 - i, i, 1, 0, 0);
      chk($sformatf("c manual Y sel%0d", i), c_y, i == 3 ? 0 : 4 - i);
      chk($sformatf("c manual err sel%0d", i), c_err, i == 3 ? 1 : 0);
      chk($sformatf("c manual ch sel%0d", i), c_ch, i);
    end
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_a($sformatf("scan s%0d", i), 4 - (i % 4), i % 4, 1, i == 4 ? 1 : 0, 0);
    end
    tick();
    chk_a("scan to ch2", 2, 2, 1, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("pause%0d", i), 2, 2, 0, 0, 0);
    end
    en = 1'b1;
    tick();
    chk_a("resume ch3", 1, 3, 1, 0, 0);
    tick();
    chk_a("resume wrap", 4, 0, 1, 1, 0);
    tick();
    tick();
    chk_a("pre-switch ch2", 2, 2, 1, 0, 0);
    mode = 1'b0;
    sel = 2'd1;
    tick();
    chk_a("switch to manual", 3, 1, 1, 0, 0);
    mode = 1'b1;
    tick();
    chk_a("switch to scan", 4, 0, 1, 0, 0);
    tick();
    tick();
    tick();
    chk_a("pre-reset ch3", 1, 3, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_a("async reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 0) chk_a("after reset", 4, 0, 1, 0, 0);
      chk($sformatf("dwell ch s%0d", i), b_ch, (i / 3) % 4);
      chk($sformatf("dwell Y s%0d", i), b_y, 4 - ((i / 3) % 4));
      chk($sformatf("dwell wrap s%0d", i), b_wrap, i == 12 ? 1 : 0);
      chk($sformatf("dwell valid s%0d", i), b_valid, 1);
      chk($sformatf("c3 ch s%0d", i), c_ch, i % 3);
      chk($sformatf("c3 wrap s%0d", i), c_wrap, (i > 0 && i % 3 == 0) ? 1 : 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
